rng_stim_bank: RTL

Parametrised successor to the single-channel random number generator used by out-of-context wrappers. It drives `NUM_CH` independent Galois LFSR stimulus channels into a DUT's unpinned inputs, with free-run, hold, single-step and reseed modes. It also compacts a wide DUT result bus into a few pins through a MISR signature register. This lets wide OOC designs go through bitstream generation without I/O overutilization, and without the tool pruning logic that has no observable output.

---
 rtl/rng_pkg.sv | 97 +++++++++
 rtl/lfsr_cell.sv | 50 +++++
 rtl/rng_stim_bank.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rng_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : rng_pkg                                                        |
// | Purpose : Shared types and helpers for rng_stim_bank: mode/state enums,  |
// |           maximal-length Galois tap table, seed derivation and the       |
// |           XOR-fold helpers used by the MISR and the signature pins.      |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package rng_pkg;

   // Widest result bus fold32 can compact; callers zero-extend up to this.
   localparam int unsigned FOLD_MAX = 1024;

   typedef enum logic [1:0] {
      MODE_FREE   = 2'b00,
      MODE_HOLD   = 2'b01,
      MODE_STEP   = 2'b10,
      MODE_RESEED = 2'b11
   } mode_e;

   typedef enum logic [0:0] {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Right-shift Galois feedback masks; bit (width-1) is always set.
   function automatic logic [31:0] lfsr_taps(input int unsigned width);
      case (width)
         2:       return 32'h0000_0003;
         3:       return 32'h0000_0006;
         4:       return 32'h0000_000C;
         5:       return 32'h0000_0014;
         6:       return 32'h0000_0030;
         7:       return 32'h0000_0060;
         8:       return 32'h0000_00B8;
         9:       return 32'h0000_0110;
         10:      return 32'h0000_0240;
         11:      return 32'h0000_0500;
         12:      return 32'h0000_0829;
         13:      return 32'h0000_100D;
         14:      return 32'h0000_2015;
         15:      return 32'h0000_6000;
         16:      return 32'h0000_D008;
         17:      return 32'h0001_2000;
         18:      return 32'h0002_0400;
         19:      return 32'h0004_0023;
         20:      return 32'h0009_0000;
         21:      return 32'h0014_0000;
         22:      return 32'h0030_0000;
         23:      return 32'h0042_0000;
         24:      return 32'h00E1_0000;
         25:      return 32'h0120_0000;
         26:      return 32'h0200_0023;
         27:      return 32'h0400_0013;
         28:      return 32'h0900_0000;
         29:      return 32'h1400_0000;
         30:      return 32'h2000_0029;
         31:      return 32'h4800_0000;
         32:      return 32'h8020_0003;
         default: return 32'h0000_0000;
      endcase
   endfunction

   // Channel k seed: (base + 2k) masked to width; zero is forced to 1 so a
   // channel can never sit in the LFSR lock-up state.
   function automatic logic [31:0] chan_seed(input int unsigned base,
                                             input int unsigned k,
                                             input int unsigned width);
      logic [31:0] mask;
      logic [31:0] v;
      mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      v    = (base + 2 * k) & mask;
      return (v == 32'd0) ? 32'd1 : v;
   endfunction

   // XOR of all 32-bit chunks of a zero-padded bus.
   function automatic logic [31:0] fold32(input logic [FOLD_MAX-1:0] d);
      logic [31:0] r;
      r = '0;
      for (int c = 0; c < int'(FOLD_MAX / 32); c++) begin
         r ^= d[c*32 +: 32];
      end
      return r;
   endfunction

   // XOR of n-bit chunks of m (upper chunk zero-padded); result in low n bits.
   function automatic logic [31:0] fold_n(input logic [31:0] m, input int n);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         r[i % n] = r[i % n] ^ m[i];
      end
      return r;
   endfunction

endpackage : rng_pkg
`default_nettype wire

// File: rtl/lfsr_cell.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : lfsr_cell                                                      |
// | Purpose : One right-shift Galois LFSR register with seed load, advance   |
// |           enable and an XOR inject port (zero for stimulus channels,     |
// |           the folded result bus when used as a MISR).                    |
// | Ports   : clk, reset (sync, active-low), load, adv, inject[WIDTH],       |
// |           value[WIDTH] (current register contents)                       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module lfsr_cell
   import rng_pkg::*;
#(
   parameter int unsigned           WIDTH = 32,
   parameter logic [WIDTH-1:0]      SEED  = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             adv,
   input  logic [WIDTH-1:0] inject,
   output logic [WIDTH-1:0] value
);

   localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

   logic [WIDTH-1:0] lfsr_d;
   logic [WIDTH-1:0] lfsr_q;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = SEED;
      end else if (adv) begin
         lfsr_d = ((lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0)) ^ inject;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign value = lfsr_q;

endmodule : lfsr_cell
`default_nettype wire

// File: rtl/rng_stim_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : rng_stim_bank                                                  |
// | Purpose : NUM_CH Galois LFSR stimulus channels (free/hold/step/reseed)   |
// |           plus a 32-bit MISR that compacts a wide result bus into a      |
// |           SIG_WIDTH-pin signature, so OOC designs keep their logic.      |
// | Ports   : clk, reset (sync, active-low), mode[2], step,                  |
// |           random_bus[NUM_CH*CH_WIDTH], valid, adv_count[16],             |
// |           misr_in[MISR_IN_WIDTH], misr_en, signature[SIG_WIDTH]          |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module rng_stim_bank
   import rng_pkg::*;
#(
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned CH_WIDTH      = 32,
   parameter int unsigned SEED_BASE     = 3,
   parameter int unsigned MISR_IN_WIDTH = 64,
   parameter int unsigned SIG_WIDTH     = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [1:0]                   mode,
   input  logic                         step,
   output logic [NUM_CH*CH_WIDTH-1:0]   random_bus,
   output logic                         valid,
   output logic [15:0]                  adv_count,
   input  logic [MISR_IN_WIDTH-1:0]     misr_in,
   input  logic                         misr_en,
   output logic [SIG_WIDTH-1:0]         signature
);

   mode_e                mode_w;
   state_e               state_d,     state_q;
   logic                 valid_d,     valid_q;
   logic [15:0]          adv_count_d, adv_count_q;
   logic                 step_d,      step_q;
   logic                 rise_d,      rise_q;
   logic [SIG_WIDTH-1:0] sig_d,       sig_q;
   logic                 ch_load;
   logic                 ch_adv;
   logic [FOLD_MAX-1:0]  misr_wide;
   logic [31:0]          misr_m;

   assign mode_w = mode_e'(mode);

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      adv_count_d = adv_count_q;
      step_d      = step;
      // Only an edge seen while already in STEP is remembered; edges in any
      // other mode are dropped rather than replayed on entry to STEP.
      rise_d      = step & ~step_q & (mode_w == MODE_STEP);
      ch_load     = 1'b0;
      ch_adv      = 1'b0;
      case (state_q)
         ST_LOAD: begin
            state_d = ST_RUN;
            valid_d = 1'b1;
         end
         ST_RUN: begin
            case (mode_w)
               MODE_FREE:   ch_adv = 1'b1;
               MODE_HOLD:   ch_adv = 1'b0;
               MODE_STEP:   ch_adv = rise_q;
               MODE_RESEED: begin
                  ch_load     = 1'b1;
                  state_d     = ST_LOAD;
                  valid_d     = 1'b0;
                  adv_count_d = '0;
               end
               default:     ch_adv = 1'b0;
            endcase
         end
         default: state_d = ST_LOAD;
      endcase
      if (ch_adv) begin
         adv_count_d = adv_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_LOAD;
         valid_q     <= 1'b0;
         adv_count_q <= '0;
         step_q      <= 1'b0;
         rise_q      <= 1'b0;
         sig_q       <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         adv_count_q <= adv_count_d;
         step_q      <= step_d;
         rise_q      <= rise_d;
         sig_q       <= sig_d;
      end
   end

   for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_ch
      lfsr_cell #(
         .WIDTH (CH_WIDTH),
         .SEED  (CH_WIDTH'(chan_seed(SEED_BASE, k, CH_WIDTH)))
      ) u_cell (
         .clk    (clk),
         .reset  (reset),
         .load   (ch_load),
         .adv    (ch_adv),
         .inject ('0),
         .value  (random_bus[k*CH_WIDTH +: CH_WIDTH])
      );
   end

   always_comb begin
      misr_wide                      = '0;
      misr_wide[MISR_IN_WIDTH-1:0]   = misr_in;
   end

   // MISR is cleared only by reset; RESEED leaves it alone.
   lfsr_cell #(
      .WIDTH (32),
      .SEED  (32'd0)
   ) u_misr (
      .clk    (clk),
      .reset  (reset),
      .load   (1'b0),
      .adv    (misr_en),
      .inject (fold32(misr_wide)),
      .value  (misr_m)
   );

   assign sig_d = SIG_WIDTH'(fold_n(misr_m, int'(SIG_WIDTH)));

   assign valid      = valid_q;
   assign adv_count  = adv_count_q;
   assign signature  = sig_q;

endmodule : rng_stim_bank
`default_nettype wire
